// File: rtl/seg14_scroll_ctrl.sv
// rtl/seg14_scroll_ctrl.sv - 14-segment multi-digit scan/scroll controller with loadable glyph buffer
// Host loads raw glyphs over a valid/ready handshake; SHOW multiplexes digits and optionally scrolls.
module seg14_scroll_ctrl #(
  parameter int NUM_DIGITS    = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int SCAN_DIV      = 1000,
  parameter int SCROLL_FRAMES = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [13:0]           wr_data,
  input  logic                  wr_last,
  input  logic                  scroll_en,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [13:0]           segm
);

  localparam int LEN_W  = $clog2(MSG_DEPTH + 1);
  localparam int PTR_W  = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int SUM_W  = ((LEN_W > DIG_W) ? LEN_W : DIG_W) + 1;

  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(MSG_DEPTH - 1);
  localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0]  FRM_MAX  = FRM_W'(SCROLL_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [SCAN_W-1:0]       scan_q, scan_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [FRM_W-1:0]        frame_q, frame_d;
  logic [PTR_W-1:0]        offset_q, offset_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [13:0]             segm_q, segm_d;

  logic [13:0]             msg_q [MSG_DEPTH];
  logic                    wr_en;
  logic [PTR_W-1:0]        wr_addr;
  logic                    accept;
  logic                    scan_wrap;
  logic                    frame_done;

  logic [SUM_W-1:0]        idx_sum;
  logic [SUM_W-1:0]        rd_idx;
  logic                    blank_digit;
  logic [13:0]             glyph;

  // Ready is withheld while clr is high so a colliding write is visibly refused.
  assign wr_ready = rst_n && !clr && (state_q != ST_SHOW);
  assign busy     = (state_q == ST_LOAD);
  assign accept   = wr_valid && wr_ready;
  assign sel      = sel_q;
  assign segm     = segm_q;

  // Sum is one bit wider than either operand so the modulo input never wraps.
  assign idx_sum = SUM_W'(offset_q) + SUM_W'(digit_q);

  always_comb begin
    rd_idx = SUM_W'(digit_q);
    if (scroll_en && (len_q != '0)) begin
      rd_idx = idx_sum % SUM_W'(len_q);
    end
  end

  assign blank_digit = !scroll_en && (SUM_W'(digit_q) >= SUM_W'(len_q));
  assign glyph       = blank_digit ? 14'd0 : msg_q[rd_idx[PTR_W-1:0]];

  assign scan_wrap  = (scan_q == SCAN_MAX);
  assign frame_done = scan_wrap && (digit_q == DIG_MAX);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    scan_d   = scan_q;
    digit_d  = digit_q;
    frame_d  = frame_q;
    offset_d = offset_q;
    sel_d    = '0;
    segm_d   = '0;
    wr_en    = 1'b0;
    wr_addr  = ptr_q;

    // Counters are only ever advanced in SHOW and are zeroed by clr/reset,
    // so they are already 0 whenever SHOW is entered.
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          ptr_d   = PTR_W'(1);
          if (wr_last) begin
            state_d = ST_SHOW;
            len_d   = LEN_W'(1);
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
          if (wr_last || (ptr_q == PTR_MAX)) begin
            state_d = ST_SHOW;
            len_d   = LEN_W'(ptr_q) + LEN_W'(1);
          end
        end
      end

      ST_SHOW: begin
        sel_d  = NUM_DIGITS'(1) << digit_q;
        segm_d = glyph;
        scan_d = scan_wrap ? '0 : scan_q + SCAN_W'(1);
        if (scan_wrap) begin
          digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + DIG_W'(1);
        end
        if (!scroll_en) begin
          frame_d  = '0;
          offset_d = '0;
        end else if (frame_done) begin
          if (frame_q == FRM_MAX) begin
            frame_d  = '0;
            offset_d = ((LEN_W'(offset_q) + LEN_W'(1)) == len_q) ? '0 : offset_q + PTR_W'(1);
          end else begin
            frame_d = frame_q + FRM_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      state_d  = ST_IDLE;
      len_d    = '0;
      ptr_d    = '0;
      scan_d   = '0;
      digit_d  = '0;
      frame_d  = '0;
      offset_d = '0;
      sel_d    = '0;
      segm_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      ptr_q    <= '0;
      scan_q   <= '0;
      digit_q  <= '0;
      frame_q  <= '0;
      offset_q <= '0;
      sel_q    <= '0;
      segm_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      frame_q  <= frame_d;
      offset_q <= offset_d;
      sel_q    <= sel_d;
      segm_q   <= segm_d;
    end
  end

  // Glyph storage has no reset; only entries below len are ever displayed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/seg14_scroll_ctrl.md
Name: seg14_scroll_ctrl

Overview:
- Scan and scroll controller for the 12-digit, 14-segment multiplexed display.
- A host writes a message of raw 14-bit glyph patterns into an internal buffer over a valid/ready handshake.
- The block then time-multiplexes the digits, driving one-hot digit select plus segment pattern. It optionally scrolls the message circularly at a programmable rate.
- It replaces hard-wired text sequencing with a loadable, rate-controlled scheduler.

Parameters:
- NUM_DIGITS, 12: number of display digits; width of sel.
- MSG_DEPTH, 32: glyph buffer depth; maximum message length.
- SCAN_DIV, 1000: clk cycles each digit stays selected; must be >= 1.
- SCROLL_FRAMES, 50: full scan frames per one-position scroll step; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: discard message, return to IDLE.
- wr_valid  input  1  host glyph write request.
- wr_ready  output  1  block can accept a glyph this cycle.
- wr_data  input  14  glyph segment pattern, same bit order as segm.
- wr_last  input  1  marks final glyph of the message.
- scroll_en  input  1  1 = circular scroll; 0 = static, left-aligned.
- busy  output  1  high while in LOAD.
- sel  output  NUM_DIGITS  one-hot digit select; bit d = digit d.
- segm  output  14  segment pattern for the selected digit.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; len=0; write pointer=0; scan counter, digit index, frame counter and offset all 0.
  - sel=0, segm=0, wr_ready=0, busy=0.
  - Buffer contents are don't-care.
- FSM states IDLE, LOAD, SHOW.
  - IDLE: wr_ready=1. An accepted write (wr_valid & wr_ready) stores buf[0] and sets ptr=1.
    - If wr_last is also set, go to SHOW with len=1; otherwise go to LOAD.
  - LOAD: wr_ready=1, busy=1. Each accepted write stores buf[ptr] and increments ptr.
    - The write with wr_last=1 goes to SHOW with len=ptr+1.
    - A write landing at ptr=MSG_DEPTH-1 is treated as last regardless of wr_last, giving len=MSG_DEPTH.
  - SHOW: wr_ready=0; writes are ignored. Stays in SHOW until clr or reset.
  - clr=1 in any state: next state IDLE, len=0, ptr=0, counters cleared, sel=0, segm=0. clr has priority over a simultaneous write; that write is not accepted.
- Output blanking: in IDLE and LOAD, sel=0 and segm=0.
- Scan timing (SHOW only):
  - The scan counter runs 0..SCAN_DIV-1. On wrap, the digit index increments mod NUM_DIGITS.
  - When the digit index wraps from NUM_DIGITS-1 to 0, a frame completes.
  - All counters restart from 0 on entry to SHOW.
- Scroll timing:
  - With scroll_en=1, the frame counter runs 0..SCROLL_FRAMES-1. On its wrap, offset becomes (offset+1) mod len.
  - With scroll_en=0, offset and the frame counter are forced to 0 every cycle.
  - When len=1, offset stays 0.
- Glyph selection for digit d:
  - scroll_en=1: buf[(offset+d) mod len]. This wraps even when len < NUM_DIGITS, so short messages repeat.
  - scroll_en=0: buf[d] if d < len, else 14'b0 (blank).
- Output registration: sel and segm are registered together and always change on the same edge.
  - They reflect the digit index and offset one cycle after those change.
  - On the first cycle after entering SHOW: sel=1<<0, segm=glyph for digit 0.
- Arithmetic: len width is clog2(MSG_DEPTH+1); offset and ptr width is clog2(MSG_DEPTH). The index sum is formed one bit wider than needed before the modulo, so it never overflows.
- Reset mid-operation (SHOW or LOAD): immediate blank with all state lost; a full reload is required.

Test Plan (SCAN_DIV=2, SCROLL_FRAMES=1, NUM_DIGITS=12, MSG_DEPTH=32 unless stated):
- Reset and IDLE blanking:
  - Stimulus: assert rst_n=0 mid-SHOW.
  - Required response: sel=0 and segm=0 in the same cycle, with no clk edge needed. After release, state=IDLE and wr_ready=1.
- Static short message:
  - Stimulus: load 3 glyphs 0x3BC0, 0x2404, 0x2710 (last on the third); scroll_en=0.
  - Required response: digits 0..2 show those patterns in order, each for 2 cycles. Digits 3..11 show sel=1<<d with segm=0. The cycle repeats every 24 clk.
- Handshake and overflow (MSG_DEPTH=4):
  - Stimulus: write 5 glyphs, never asserting wr_last.
  - Required response: the 4th write moves the FSM to SHOW with len=4 and wr_ready=0. The 5th write is not accepted.
- Scrolling:
  - Stimulus: load 14 distinct glyphs G0..G13; scroll_en=1.
  - Required response: frame 0 shows digit 0 = G0 and digit 11 = G11. Frame 1 shows digit 0 = G1 and digit 11 = G12. Frame 13 shows digit 0 = G13 and digit 1 = G0.
- clr priority:
  - Stimulus: during LOAD with ptr=2, assert clr together with wr_valid.
  - Required response: next cycle the FSM is in IDLE with len=0 and busy=0. The glyph is not stored, and a fresh load starts at buf[0].
- scroll_en toggling:
  - Stimulus: drop scroll_en to 0 while offset=5.
  - Required response: next frame shows digit 0 = buf[0]. Re-enabling scroll_en resumes scrolling from offset 0.
